// File: rtl/super_counter_pkg.sv
// Shared types and helpers for the multi-channel button counter.
// Holds the per-channel FSM state encoding and the timer width helper.
package super_counter_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_HELD   = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_e;

    // Bits needed to hold values 0..n, never less than one bit.
    function automatic int cw(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debouncer, press/hold/repeat FSM
// and a press counter with sticky overflow and synchronous clear.
module btn_channel
    import super_counter_pkg::*;
#(
    parameter int COUNT_WIDTH     = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 6000000,
    parameter int REPEAT_CYCLES   = 1200000,
    parameter bit SATURATE        = 1'b0
) (
    input  logic                   clk_12m,
    input  logic                   rst,
    input  logic                   btn,
    input  logic                   clr,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   debounced,
    output logic                   press_event,
    output logic                   ovf
);

    localparam int DB_W   = cw(DEBOUNCE_CYCLES - 1);
    localparam int HOLD_W = cw(HOLD_CYCLES - 1);
    localparam int REP_W  = cw(REPEAT_CYCLES - 1);

    localparam logic [DB_W-1:0]        DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]       REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic                   sync1_reg;
    logic                   sync2_reg;
    logic                   stable_reg;
    logic [DB_W-1:0]        db_timer_reg;
    btn_state_e             state_reg;
    logic [HOLD_W-1:0]      hold_timer_reg;
    logic [REP_W-1:0]       rep_timer_reg;
    logic                   event_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   ovf_reg;
    logic                   fire_next;

    // Synchroniser and debouncer; a floating or unknown pin reads as released.
    always_ff @(posedge clk_12m) begin
        if (rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            stable_reg   <= 1'b0;
            db_timer_reg <= '0;
        end else begin
            sync1_reg <= (btn === 1'b1);
            sync2_reg <= sync1_reg;
            if (sync2_reg == stable_reg) begin
                db_timer_reg <= '0;
            end else if (db_timer_reg == DB_LAST) begin
                stable_reg   <= sync2_reg;
                db_timer_reg <= '0;
            end else begin
                db_timer_reg <= db_timer_reg + 1'b1;
            end
        end
    end

    // Event decision shared by the FSM output flop and the counter update.
    always_comb begin
        fire_next = 1'b0;
        case (state_reg)
            BTN_IDLE:   fire_next = stable_reg;
            BTN_HELD:   fire_next = stable_reg && (hold_timer_reg == HOLD_LAST);
            BTN_REPEAT: fire_next = stable_reg && (rep_timer_reg == REP_LAST);
            default:    fire_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk_12m) begin
        if (rst) begin
            state_reg      <= BTN_IDLE;
            hold_timer_reg <= '0;
            rep_timer_reg  <= '0;
            event_reg      <= 1'b0;
        end else begin
            event_reg <= fire_next;
            case (state_reg)
                BTN_IDLE: begin
                    if (stable_reg) begin
                        state_reg      <= BTN_HELD;
                        hold_timer_reg <= '0;
                    end
                end
                BTN_HELD: begin
                    if (!stable_reg) begin
                        state_reg <= BTN_IDLE;
                    end else if (hold_timer_reg == HOLD_LAST) begin
                        state_reg     <= BTN_REPEAT;
                        rep_timer_reg <= '0;
                    end else begin
                        hold_timer_reg <= hold_timer_reg + 1'b1;
                    end
                end
                BTN_REPEAT: begin
                    if (!stable_reg) begin
                        state_reg <= BTN_IDLE;
                    end else if (rep_timer_reg == REP_LAST) begin
                        rep_timer_reg <= '0;
                    end else begin
                        rep_timer_reg <= rep_timer_reg + 1'b1;
                    end
                end
                default: state_reg <= BTN_IDLE;
            endcase
        end
    end

    // Clear takes priority over a coincident event; the event pulse is unaffected.
    always_ff @(posedge clk_12m) begin
        if (rst) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (clr) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (fire_next) begin
            if (count_reg == COUNT_MAX) begin
                ovf_reg <= 1'b1;
                if (!SATURATE) begin
                    count_reg <= '0;
                end
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign count       = count_reg;
    assign debounced   = stable_reg;
    assign press_event = event_reg;
    assign ovf         = ovf_reg;

endmodule

// File: rtl/multi_button_counter.sv
// Multi-channel debounced press counter with auto-repeat and a shared
// activity LED that retriggers on any channel's press event.
module multi_button_counter
    import super_counter_pkg::*;
#(
    parameter int NUM_BTNS        = 4,
    parameter int COUNT_WIDTH     = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 6000000,
    parameter int REPEAT_CYCLES   = 1200000,
    parameter int LED_CYCLES      = 100,
    parameter bit SATURATE        = 1'b0
) (
    input  logic                            clk_12m,
    input  logic                            rst,
    input  logic [NUM_BTNS-1:0]             btn_press,
    input  logic [NUM_BTNS-1:0]             clr,
    output logic [NUM_BTNS*COUNT_WIDTH-1:0] btn_count,
    output logic [NUM_BTNS-1:0]             btn_debounced,
    output logic [NUM_BTNS-1:0]             press_event,
    output logic [NUM_BTNS-1:0]             ovf,
    output logic                            led
);

    localparam int                LED_W    = cw(LED_CYCLES);
    localparam logic [LED_W-1:0]  LED_LOAD = LED_W'(LED_CYCLES);

    logic [LED_W-1:0] led_timer_reg;
    logic             any_event;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
            btn_channel #(
                .COUNT_WIDTH     (COUNT_WIDTH),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_CYCLES     (HOLD_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES),
                .SATURATE        (SATURATE)
            ) u_chan (
                .clk_12m     (clk_12m),
                .rst         (rst),
                .btn         (btn_press[gi]),
                .clr         (clr[gi]),
                .count       (btn_count[gi*COUNT_WIDTH +: COUNT_WIDTH]),
                .debounced   (btn_debounced[gi]),
                .press_event (press_event[gi]),
                .ovf         (ovf[gi])
            );
        end
    endgenerate

    assign any_event = |press_event;

    // The timer loads the cycle after an event, so led ORs in the event
    // itself: high from the event edge for LED_CYCLES+1 cycles.
    always_ff @(posedge clk_12m) begin
        if (rst) begin
            led_timer_reg <= '0;
        end else if (any_event) begin
            led_timer_reg <= LED_LOAD;
        end else if (led_timer_reg != '0) begin
            led_timer_reg <= led_timer_reg - 1'b1;
        end
    end

    assign led = any_event || (led_timer_reg != '0);

endmodule
